// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    // Matches the CPU datapath width.
    localparam int WORD_SIZE_DEF = 16;

    // Width of the latency and starvation counters (parameters are limited to 1..15).
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single-ported fixed-latency memory.
// The data side has priority; a saturating starvation counter forces a
// fetch grant after MAX_WAIT consecutive data grants made while a fetch waits.
//
// state | meaning
// IDLE  | arbitrate on the sampled requests, latch the winner's request
// BUSY  | drive the memory strobe for LATENCY cycles, capture read data at the end
// RESP  | one-cycle ack to the owner; the return to IDLE is the dead cycle
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int LATENCY   = 2,
    parameter int MAX_WAIT  = 3
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic                 i_ack,
    output logic [WORD_SIZE-1:0] i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_ack,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(MAX_WAIT);

    state_t               state;
    state_t               state_nxt;
    owner_t               owner;
    owner_t               grant_own;
    logic                 grant;
    logic                 we_q;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [CNT_W-1:0]     lat_cnt;
    logic [CNT_W-1:0]     starve_cnt;
    logic                 last_beat;

    assign last_beat = (state == BUSY) && (lat_cnt == '0);

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration and next-state decode; forced fetch beats data priority.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_own = OWN_D;
        case (state)
            IDLE: begin
                if (i_req && (starve_cnt == STARVE_MAX)) begin
                    grant     = 1'b1;
                    grant_own = OWN_I;
                end else if (d_req) begin
                    grant     = 1'b1;
                    grant_own = OWN_D;
                end else if (i_req) begin
                    grant     = 1'b1;
                    grant_own = OWN_I;
                end
                if (grant) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (lat_cnt == '0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch the winning request; later input changes are ignored until the next grant.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            owner   <= OWN_I;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant) begin
            owner  <= grant_own;
            we_q   <= (grant_own == OWN_D) && d_we;
            addr_q <= (grant_own == OWN_D) ? d_addr : i_addr;
            // Fetches carry no write data, so the last data-side value is kept.
            if (grant_own == OWN_D) begin
                wdata_q <= d_wdata;
            end
        end
    end

    // Latency down-counter: loaded on grant, terminal count ends the strobe.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            lat_cnt <= '0;
        end else if (grant) begin
            lat_cnt <= LAT_INIT;
        end else if ((state == BUSY) && (lat_cnt != '0)) begin
            lat_cnt <= lat_cnt - 1'b1;
        end
    end

    // Starvation counter: counts data grants that bypass a waiting fetch, saturating.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (grant_own == OWN_I) begin
                starve_cnt <= '0;
            end else if (i_req && (starve_cnt < STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    // Capture read data in the last strobe cycle into the owner's register only.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            i_rdata <= '0;
            d_rdata <= '0;
        end else if (last_beat && !we_q) begin
            if (owner == OWN_I) begin
                i_rdata <= mem_rdata;
            end else begin
                d_rdata <= mem_rdata;
            end
        end
    end

    assign mem_read  = (state == BUSY) && !we_q;
    assign mem_write = (state == BUSY) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_ack     = (state == RESP) && (owner == OWN_I);
    assign d_ack     = (state == RESP) && (owner == OWN_D);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int W   = 16;
    localparam int LAT = 2;
    localparam int MW  = 3;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         i_req, d_req, d_we;
    logic [W-1:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic         i_ack, d_ack, mem_read, mem_write, busy;
    logic [W-1:0] i_rdata, d_rdata, mem_addr, mem_wdata;

    always #5 Clk = ~Clk;

    mem_port_arbiter #(.WORD_SIZE(W), .LATENCY(LAT), .MAX_WAIT(MW)) dut (
        .Clk(Clk), .Reset(Reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // 64-word memory device (address aliased on the low 6 bits)
    logic [W-1:0] mem_arr [64];
    assign mem_rdata = mem_read ? mem_arr[mem_addr[5:0]] : '0;

    int checks = 0;
    int errors = 0;
    int e = 0;

    // reference model: one transfer record, its grant edge and when the port is free again
    bit           m_valid;
    int           m_g;
    int           free_edge;
    bit           m_own;
    bit           m_we;
    logic [W-1:0] m_addr, m_wd, m_rd;
    int           starve;
    logic [W-1:0] ref_mem [64];
    logic [W-1:0] exp_ir, exp_dr;

    bit ack_log[$];
    int n_i = 0, n_d = 0, last_i_e = 0, last_d_e = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, expv, e);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; free_edge = 0; starve = 0; m_own = 0; m_we = 0;
        m_addr = '0; m_wd = '0; m_rd = '0; exp_ir = '0; exp_dr = '0;
    endtask

    task automatic preload(input int a, input logic [W-1:0] v);
        mem_arr[a] = v;
        ref_mem[a] = v;
    endtask

    // decide the grant for the coming edge from the rules, using the inputs now driven
    task automatic model_decide();
        bit do_g, own;
        do_g = 0; own = 0;
        if (Reset || (e + 1) < free_edge) return;
        if (i_req && starve == MW) begin do_g = 1; own = 0; end
        else if (d_req) begin
            do_g = 1; own = 1;
            if (i_req && starve < MW) starve++;
        end
        else if (i_req) begin do_g = 1; own = 0; end
        if (do_g) begin
            m_valid   = 1;
            m_g       = e + 1;
            free_edge = e + 1 + LAT + 2;
            m_own     = own;
            m_we      = own ? d_we : 1'b0;
            m_addr    = own ? d_addr : i_addr;
            if (own) m_wd = d_wdata;
            m_rd      = ref_mem[m_addr[5:0]];
            if (!own) starve = 0;
        end
    endtask

    task automatic check_cycle();
        bit strobe, ack;
        strobe = m_valid && (e >= m_g) && (e < m_g + LAT);
        ack    = m_valid && (e == m_g + LAT);
        if (ack) begin
            if (m_we) ref_mem[m_addr[5:0]] = m_wd;
            else if (m_own) exp_dr = m_rd;
            else exp_ir = m_rd;
        end
        chk("mem_read", mem_read, strobe && !m_we);
        chk("mem_write", mem_write, strobe && m_we);
        chk("busy", busy, strobe || ack);
        chk("i_ack", i_ack, ack && !m_own);
        chk("d_ack", d_ack, ack && m_own);
        chk("mem_addr", mem_addr, m_addr);
        if (strobe && m_we) chk("mem_wdata", mem_wdata, m_wd);
        chk("i_rdata", i_rdata, exp_ir);
        chk("d_rdata", d_rdata, exp_dr);
        if (i_ack) begin ack_log.push_back(1'b0); n_i++; last_i_e = e; end
        if (d_ack) begin ack_log.push_back(1'b1); n_d++; last_d_e = e; end
    endtask

    // one clock: memory write for this cycle, model grant, edge, then check at the falling edge
    task automatic tick();
        if (mem_write) mem_arr[mem_addr[5:0]] = mem_wdata;
        model_decide();
        @(posedge Clk);
        e++;
        @(negedge Clk);
        check_cycle();
    endtask

    // run until each wanted side is acked, dropping its request on the ack
    task automatic serve(input bit want_i, input bit want_d, input int budget);
        bit gi, gd;
        gi = !want_i; gd = !want_d;
        for (int k = 0; k < budget && !(gi && gd); k++) begin
            tick();
            if (i_ack) begin i_req = 0; gi = 1; end
            if (d_ack) begin d_req = 0; gd = 1; end
        end
        chk("serve_done", {30'd0, gi, gd}, 32'd3);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_acks"}, {i_ack, d_ack}, 0);
        chk({tag, "_strobes"}, {mem_read, mem_write}, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_rdata"}, {i_rdata, d_rdata}, 0);
    endtask

    initial begin
        int t0, nd0;
        logic [W-1:0] prev, v8;
        bit exp_pat [5];

        Reset = 1; i_req = 0; d_req = 0; d_we = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        for (int k = 0; k < 64; k++) preload(k, W'($urandom));
        model_reset();
        repeat (2) @(negedge Clk);
        check_all_zero("reset");
        Reset = 0;

        // single fetch
        preload(6'h10, 16'hABCD);
        i_addr = 16'h0010; i_req = 1; t0 = e;
        serve(1, 0, 20);
        chk("fetch_lat", last_i_e - t0, 3);
        chk("fetch_rdata", i_rdata, 16'hABCD);
        chk("fetch_no_dack", n_d, 0);

        // data write
        prev = d_rdata;
        d_req = 1; d_we = 1; d_addr = 16'h0020; d_wdata = 16'h1234;
        serve(0, 1, 20);
        chk("wr_mem", mem_arr[6'h20], 16'h1234);
        chk("wr_d_rdata", d_rdata, prev);
        repeat (2) tick();

        // collision: data first, fetch one occupancy later
        preload(6'h30, 16'h5555);
        preload(6'h00, 16'h7777);
        d_req = 1; d_we = 0; d_addr = 16'h0030;
        i_req = 1; i_addr = 16'h0040;
        serve(1, 1, 30);
        chk("coll_d_rdata", d_rdata, 16'h5555);
        chk("coll_i_rdata", i_rdata, 16'h7777);
        chk("coll_gap", last_i_e - last_d_e, 4);
        repeat (2) tick();

        // starvation: both held, expect D D D I D
        ack_log.delete();
        exp_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        d_req = 1; d_we = 0; d_addr = 16'h0005; i_req = 1; i_addr = 16'h0007;
        for (int k = 0; k < 80 && ack_log.size() < 5; k++) begin
            tick();
            if (d_ack) d_addr = d_addr + 16'd1;
            if (i_ack) i_addr = i_addr + 16'd1;
        end
        d_req = 0; i_req = 0;
        chk("starve_count", ack_log.size() >= 5, 1);
        for (int k = 0; k < 5 && k < ack_log.size(); k++)
            chk("starve_order", ack_log[k], exp_pat[k]);
        repeat (8) tick();

        // latching: address change and req drop during BUSY
        nd0 = n_d;
        d_req = 1; d_we = 0; d_addr = 16'h0050;
        tick();
        chk("latch_rd1", mem_read, 1);
        chk("latch_addr1", mem_addr, 16'h0050);
        d_addr = 16'h0060; d_req = 0;
        tick();
        chk("latch_rd2", mem_read, 1);
        chk("latch_addr2", mem_addr, 16'h0050);
        repeat (4) tick();
        chk("latch_acks", n_d - nd0, 1);

        // reset in the second strobe cycle of a data read
        v8 = ref_mem[8];
        nd0 = n_d;
        d_req = 1; d_we = 0; d_addr = 16'h0008;
        tick();
        tick();
        chk("rst_pre_rd", mem_read, 1);
        Reset = 1;
        #1;
        check_all_zero("rst_mid");
        model_reset();
        tick();
        Reset = 0;
        serve(0, 1, 20);
        chk("rst_acks", n_d - nd0, 1);
        chk("rst_reissue", d_rdata, v8);
        repeat (2) tick();

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (i_ack) i_req = ($urandom_range(1) == 0);
            else if (!i_req) i_req = ($urandom_range(3) == 0);
            else if ($urandom_range(31) == 0) i_req = 0;
            if ($urandom_range(3) == 0) i_addr = W'($urandom);
            if (d_ack) d_req = ($urandom_range(2) != 0);
            else if (!d_req) d_req = ($urandom_range(2) == 0);
            else if ($urandom_range(31) == 0) d_req = 0;
            if ($urandom_range(3) == 0) begin
                d_addr  = W'($urandom);
                d_we    = $urandom_range(1) == 1;
                d_wdata = W'($urandom);
            end
        end
        i_req = 0; d_req = 0;
        repeat (8) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
